// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle arena pipeline.
//   dir_t        : bike heading encoding (matches the player_dir port field)
//   *_COLOR      : reserved palette enums seen in the trail RAM / sprite path
//   NOSE_*       : offsets from a bike's sprite origin to its collision pixel
//   H_RES, V_RES : visible arena size in pixels
package tron_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [3:0] BG_COLOR    = 4'h8;
    localparam logic [3:0] EMPTY_COLOR = 4'h0;
    localparam logic [3:0] TRANSPARENT = 4'hF;

    localparam int NOSE_FWD  = 14;
    localparam int NOSE_SIDE = 3;
    localparam int X_BIAS    = 16;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

endpackage

// File: rtl/nose_point_calc.sv
// Combinational nose-pixel locator for one bike.
//   x, y       : bike sprite origin (10-bit screen coordinates)
//   dir        : heading, encoded as tron_pkg::dir_t
//   nose_x/y   : collision pixel, 10-bit modular arithmetic
//   off_screen : nose lies outside the visible arena (includes wrapped underflow)
module nose_point_calc
    import tron_pkg::*;
#(
    parameter int FWD  = NOSE_FWD,
    parameter int SIDE = NOSE_SIDE,
    parameter int BIAS = X_BIAS,
    parameter int HRES = H_RES,
    parameter int VRES = V_RES
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [1:0] dir,
    output logic [9:0] nose_x,
    output logic [9:0] nose_y,
    output logic       off_screen
);

    localparam logic [9:0]  FWD_W  = 10'(FWD);
    localparam logic [9:0]  SIDE_W = 10'(SIDE);
    localparam logic [9:0]  BIAS_W = 10'(BIAS);
    localparam logic [10:0] HRES_W = 11'(HRES);
    localparam logic [10:0] VRES_W = 11'(VRES);

    always_comb begin
        nose_x = x + SIDE_W - BIAS_W;
        nose_y = y - FWD_W;
        case (dir_t'(dir))
            DIR_UP: begin
                nose_x = x + SIDE_W - BIAS_W;
                nose_y = y - FWD_W;
            end
            DIR_DOWN: begin
                nose_x = x + SIDE_W - BIAS_W;
                nose_y = y + FWD_W;
            end
            DIR_LEFT: begin
                nose_x = x - FWD_W - BIAS_W;
                nose_y = y + SIDE_W;
            end
            DIR_RIGHT: begin
                nose_x = x + FWD_W - BIAS_W;
                nose_y = y + SIDE_W;
            end
            default: ;
        endcase
    end

    // A nose that wrapped below zero lands near 1023 and is caught here too.
    assign off_screen = ({1'b0, nose_x} >= HRES_W) || ({1'b0, nose_y} >= VRES_W);

endmodule

// File: rtl/multi_bike_compositor.sv
// Per-pixel compositor and collision detector for NUM_PLAYERS light-cycles.
//   Clk, Reset          : system clock, synchronous active-high reset
//   frame_clk           : ~60 Hz frame tick, asynchronous to Clk
//   pix_req/DrawX/DrawY : scan position, valid when pix_req is high
//   sprite_color        : bike sprite enum for the current scan pixel
//   player_x/y/dir      : packed per-bike position and heading
//   player_alive        : per-bike enable for collision accumulation
//   ram_rd_addr/data    : trail frame RAM read port (data one cycle after address)
//   color_enum/valid    : composited pixel, two cycles after pix_req
//   crash_flags/valid   : per-bike crash result, updated once per frame
module multi_bike_compositor #(
    parameter int NUM_PLAYERS = 2,
    parameter int COLOR_W     = 4,
    parameter int H_RES       = tron_pkg::H_RES,
    parameter int V_RES       = tron_pkg::V_RES,
    parameter int LANE_STRIDE = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR    = COLOR_W'(tron_pkg::BG_COLOR),
    parameter logic [COLOR_W-1:0] EMPTY_COLOR = COLOR_W'(tron_pkg::EMPTY_COLOR),
    parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(tron_pkg::TRANSPARENT),
    parameter int NOSE_FWD    = tron_pkg::NOSE_FWD,
    parameter int NOSE_SIDE   = tron_pkg::NOSE_SIDE,
    parameter int X_BIAS      = tron_pkg::X_BIAS
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic                     pix_req,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [COLOR_W-1:0]       sprite_color,
    input  logic [NUM_PLAYERS*10-1:0] player_x,
    input  logic [NUM_PLAYERS*10-1:0] player_y,
    input  logic [NUM_PLAYERS*2-1:0] player_dir,
    input  logic [NUM_PLAYERS-1:0]   player_alive,
    output logic [18:0]              ram_rd_addr,
    input  logic [15:0]              ram_rd_data,
    output logic [COLOR_W-1:0]       color_enum,
    output logic                     color_valid,
    output logic [NUM_PLAYERS-1:0]   crash_flags,
    output logic                     crash_valid
);

    localparam logic [18:0] ROW_WORDS = 19'(H_RES / 2);

    // Two pixels per RAM word, so the column is halved.
    assign ram_rd_addr = 19'(DrawX >> 1) + 19'(DrawY) * ROW_WORDS;

    // ---------------- stage 1 ----------------
    logic                      valid_s1;
    logic [9:0]                draw_x_s1;
    logic [9:0]                draw_y_s1;
    logic [COLOR_W-1:0]        sprite_s1;
    logic [NUM_PLAYERS*10-1:0] pos_x_s1;
    logic [NUM_PLAYERS*10-1:0] pos_y_s1;
    logic [NUM_PLAYERS*2-1:0]  dir_s1;
    logic [NUM_PLAYERS-1:0]    alive_s1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_s1  <= 1'b0;
            draw_x_s1 <= '0;
            draw_y_s1 <= '0;
            sprite_s1 <= TRANSPARENT;
            pos_x_s1  <= '0;
            pos_y_s1  <= '0;
            dir_s1    <= '0;
            alive_s1  <= '0;
        end else begin
            valid_s1  <= pix_req;
            draw_x_s1 <= DrawX;
            draw_y_s1 <= DrawY;
            sprite_s1 <= sprite_color;
            pos_x_s1  <= player_x;
            pos_y_s1  <= player_y;
            dir_s1    <= player_dir;
            alive_s1  <= player_alive;
        end
    end

    // ---------------- nose points ----------------
    logic [9:0]             nose_x [NUM_PLAYERS];
    logic [9:0]             nose_y [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] off_screen;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_nose
        nose_point_calc #(
            .FWD  (NOSE_FWD),
            .SIDE (NOSE_SIDE),
            .BIAS (X_BIAS),
            .HRES (H_RES),
            .VRES (V_RES)
        ) u_nose (
            .x          (pos_x_s1[i*10 +: 10]),
            .y          (pos_y_s1[i*10 +: 10]),
            .dir        (dir_s1[i*2 +: 2]),
            .nose_x     (nose_x[i]),
            .nose_y     (nose_y[i]),
            .off_screen (off_screen[i])
        );
    end

    // ---------------- frame tick synchroniser ----------------
    logic [2:0] frame_sync;
    logic       frame_edge;
    // The first edge after reset only opens a fresh frame; it has no
    // complete frame of evidence behind it, so nothing is reported.
    logic       armed;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_sync <= '0;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
        end
    end

    assign frame_edge = frame_sync[1] & ~frame_sync[2];

    // ---------------- stage 2 combinational ----------------
    logic [COLOR_W-1:0]     lane;
    logic                   lane_is_trail;
    logic [NUM_PLAYERS-1:0] hit_now;
    logic [NUM_PLAYERS-1:0] wall;
    logic [NUM_PLAYERS-1:0] hit_acc;
    logic [NUM_PLAYERS-1:0] hit_acc_next;

    always_comb begin
        lane          = draw_x_s1[0] ? ram_rd_data[LANE_STRIDE +: COLOR_W]
                                     : ram_rd_data[0 +: COLOR_W];
        lane_is_trail = (lane != BG_COLOR) && (lane != EMPTY_COLOR);
        hit_now       = '0;
        wall          = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            hit_now[i] = valid_s1 && alive_s1[i] && lane_is_trail &&
                         (draw_x_s1 == nose_x[i]) && (draw_y_s1 == nose_y[i]);
            wall[i]    = alive_s1[i] && off_screen[i];
        end
        // A hit landing on the edge cycle goes into the freshly cleared
        // accumulator; a bike that is not alive drops its accumulator now.
        hit_acc_next = ((frame_edge ? '0 : hit_acc) | hit_now) & player_alive;
    end

    // ---------------- stage 2 registers ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_enum  <= EMPTY_COLOR;
            color_valid <= 1'b0;
            hit_acc     <= '0;
            crash_flags <= '0;
            crash_valid <= 1'b0;
            armed       <= 1'b0;
        end else begin
            color_enum  <= (sprite_s1 != TRANSPARENT) ? sprite_s1 : lane;
            color_valid <= valid_s1;
            hit_acc     <= hit_acc_next;
            crash_valid <= frame_edge && armed;
            if (frame_edge) begin
                armed <= 1'b1;
                if (armed) begin
                    crash_flags <= hit_acc | wall;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_bike_compositor.sv
module tb_multi_bike_compositor;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic        pix_req;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [3:0]  sprite_color;
    logic [19:0] player_x;
    logic [19:0] player_y;
    logic [3:0]  player_dir;
    logic [1:0]  player_alive;
    logic [18:0] ram_rd_addr;
    logic [15:0] ram_rd_data;
    logic [3:0]  color_enum;
    logic        color_valid;
    logic [1:0]  crash_flags;
    logic        crash_valid;

    int compared;
    int mismatched;

    // Trail RAM model: one special word at the bike-0 nose address.
    logic [18:0] hot_addr;
    logic [15:0] hot_word;
    logic [15:0] bg_word;

    multi_bike_compositor dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .pix_req      (pix_req),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .sprite_color (sprite_color),
        .player_x     (player_x),
        .player_y     (player_y),
        .player_dir   (player_dir),
        .player_alive (player_alive),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .color_enum   (color_enum),
        .color_valid  (color_valid),
        .crash_flags  (crash_flags),
        .crash_valid  (crash_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        ram_rd_data <= (ram_rd_addr == hot_addr) ? hot_word : bg_word;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_bikes(input logic [9:0] x0, input logic [9:0] y0, input logic [1:0] d0,
                             input logic [9:0] x1, input logic [9:0] y1, input logic [1:0] d1,
                             input logic [1:0] alive);
        player_x     = {x1, x0};
        player_y     = {y1, y0};
        player_dir   = {d1, d0};
        player_alive = alive;
        step();
    endtask

    // Presents a single pixel for one cycle and lets the pipeline drain.
    task automatic present_pixel(input logic [9:0] x, input logic [9:0] y, input logic [3:0] spr);
        pix_req      = 1'b1;
        DrawX        = x;
        DrawY        = y;
        sprite_color = spr;
        step();
        pix_req      = 1'b0;
        sprite_color = 4'hF;
        step();
        step();
    endtask

    // Raises frame_clk, counts crash_valid pulses within a bounded window.
    task automatic frame_tick(output int pulses, output logic [1:0] flags);
        pulses    = 0;
        flags     = 2'bxx;
        frame_clk = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (crash_valid === 1'b1) begin
                pulses++;
                flags = crash_flags;
            end
        end
        frame_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) step();
        compared++;
        if (color_enum !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_color_enum got=%h want=0", color_enum);
        end
        compared++;
        if (color_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_color_valid got=%b want=0", color_valid);
        end
        compared++;
        if (crash_flags !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_crash_flags got=%b want=00", crash_flags);
        end
        compared++;
        if (crash_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_crash_valid got=%b want=0", crash_valid);
        end
        Reset = 1'b0;
        step();
    endtask

    // First synchronised edge after reset must not report.
    task automatic test_arming();
        int pulses;
        logic [1:0] flags;
        frame_tick(pulses, flags);
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL arming_no_pulse got=%0d want=0", pulses);
        end
    endtask

    task automatic test_latency_lanes();
        bg_word      = 16'h0503;
        pix_req      = 1'b1;
        DrawX        = 10'd10;
        DrawY        = 10'd0;
        sprite_color = 4'hF;
        #1;
        compared++;
        if (ram_rd_addr !== 19'd5) begin
            mismatched++;
            $display("FAIL addr_x10 got=%0d want=5", ram_rd_addr);
        end
        step();
        DrawX = 10'd11;
        compared++;
        if (color_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_early_valid got=%b want=0", color_valid);
        end
        step();
        pix_req = 1'b0;
        compared++;
        if (color_valid !== 1'b1 || color_enum !== 4'h3) begin
            mismatched++;
            $display("FAIL lane0 got=%b/%h want=1/3", color_valid, color_enum);
        end
        step();
        compared++;
        if (color_valid !== 1'b1 || color_enum !== 4'h5) begin
            mismatched++;
            $display("FAIL lane1 got=%b/%h want=1/5", color_valid, color_enum);
        end
        step();
        compared++;
        if (color_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_tail_valid got=%b want=0", color_valid);
        end
        DrawX        = 10'd87;
        DrawY        = 10'd186;
        #1;
        compared++;
        if (ram_rd_addr !== 19'd59563) begin
            mismatched++;
            $display("FAIL addr_nose got=%0d want=59563", ram_rd_addr);
        end
        step();
    endtask

    task automatic test_sprite_overlay();
        bg_word      = 16'h0006;
        pix_req      = 1'b1;
        DrawX        = 10'd20;
        DrawY        = 10'd3;
        sprite_color = 4'h2;
        step();
        sprite_color = 4'hF;
        step();
        pix_req = 1'b0;
        compared++;
        if (color_valid !== 1'b1 || color_enum !== 4'h2) begin
            mismatched++;
            $display("FAIL sprite_over got=%b/%h want=1/2", color_valid, color_enum);
        end
        step();
        compared++;
        if (color_valid !== 1'b1 || color_enum !== 4'h6) begin
            mismatched++;
            $display("FAIL sprite_transparent got=%b/%h want=1/6", color_valid, color_enum);
        end
        bg_word = 16'h0808;
        step();
    endtask

    task automatic check_frame(input string name, input logic [1:0] want);
        int pulses;
        logic [1:0] flags;
        frame_tick(pulses, flags);
        compared++;
        if (pulses !== 1 || flags !== want) begin
            mismatched++;
            $display("FAIL %s got pulses=%0d flags=%b want pulses=1 flags=%b",
                     name, pulses, flags, want);
        end
    endtask

    task automatic test_trail_hit();
        set_bikes(10'd100, 10'd200, 2'b00, 10'd300, 10'd300, 2'b11, 2'b11);
        hot_word = 16'h0400;
        present_pixel(10'd87, 10'd186, 4'hF);
        check_frame("trail_hit", 2'b01);
        check_frame("trail_cleared", 2'b00);
    endtask

    task automatic test_non_obstacles();
        hot_word = 16'h0800;
        present_pixel(10'd87, 10'd186, 4'hF);
        check_frame("bg_not_obstacle", 2'b00);
        hot_word = 16'h0000;
        present_pixel(10'd87, 10'd186, 4'hF);
        check_frame("empty_not_obstacle", 2'b00);
        hot_word = 16'h0004;
        present_pixel(10'd87, 10'd186, 4'hF);
        check_frame("other_lane_ignored", 2'b00);
    endtask

    task automatic test_multi_bike();
        set_bikes(10'd100, 10'd200, 2'b00, 10'd100, 10'd172, 2'b01, 2'b11);
        hot_word = 16'h0400;
        present_pixel(10'd87, 10'd186, 4'h2);
        check_frame("multi_bike_same_nose", 2'b11);
    endtask

    task automatic test_wall_liveness();
        set_bikes(10'd300, 10'd300, 2'b00, 10'd5, 10'd100, 2'b10, 2'b11);
        check_frame("wall_underflow", 2'b10);
        set_bikes(10'd300, 10'd300, 2'b00, 10'd5, 10'd100, 2'b10, 2'b01);
        check_frame("wall_dead_bike", 2'b00);
    endtask

    // Hit lands on the exact cycle the synchronised edge is seen.
    task automatic test_back_to_back();
        set_bikes(10'd100, 10'd200, 2'b00, 10'd300, 10'd300, 2'b11, 2'b11);
        hot_word  = 16'h0400;
        frame_clk = 1'b1;
        step();
        pix_req = 1'b1;
        DrawX   = 10'd87;
        DrawY   = 10'd186;
        step();
        pix_req = 1'b0;
        step();
        compared++;
        if (crash_valid !== 1'b1 || crash_flags !== 2'b00) begin
            mismatched++;
            $display("FAIL race_edge_frame got valid=%b flags=%b want valid=1 flags=00",
                     crash_valid, crash_flags);
        end
        step();
        frame_clk = 1'b0;
        repeat (4) step();
        check_frame("race_next_frame", 2'b01);
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        logic [1:0] flags;
        hot_word = 16'h0400;
        present_pixel(10'd87, 10'd186, 4'hF);
        Reset = 1'b1;
        step();
        step();
        compared++;
        if (color_enum !== 4'h0 || color_valid !== 1'b0 ||
            crash_flags !== 2'b00 || crash_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_outputs got=%h/%b/%b/%b want=0/0/00/0",
                     color_enum, color_valid, crash_flags, crash_valid);
        end
        Reset = 1'b0;
        step();
        frame_tick(pulses, flags);
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL midreset_first_edge got pulses=%0d want=0", pulses);
        end
        check_frame("midreset_discarded", 2'b00);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        pix_req      = 1'b0;
        DrawX        = '0;
        DrawY        = '0;
        sprite_color = 4'hF;
        player_x     = {10'd300, 10'd100};
        player_y     = {10'd300, 10'd200};
        player_dir   = {2'b11, 2'b00};
        player_alive = 2'b11;
        hot_addr     = 19'd59563;
        hot_word     = 16'h0808;
        bg_word      = 16'h0808;

        test_reset();
        test_arming();
        test_latency_lanes();
        test_sprite_overlay();
        test_trail_hit();
        test_non_obstacles();
        test_multi_bike();
        test_wall_liveness();
        test_back_to_back();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
